// File: rtl/ram_sync_param_if.sv
// Write/read port bundle for ram_sync_param: the requester drives writes and reads,
// the RAM returns registered read data, its status flags and the clear-sweep busy flag.
interface ram_sync_param_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 3
);
  logic              en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  in;
  logic              read;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  out;
  logic              out_valid;
  logic              rd_err;
  logic              busy;

  modport master (
    output en, wr_addr, in, read, rd_addr,
    input  out, out_valid, rd_err, busy
  );

  modport slave (
    input  en, wr_addr, in, read, rd_addr,
    output out, out_valid, rd_err, busy
  );
endinterface

// File: rtl/ram_sync_param.sv
// Parametrised synchronous RAM with one write and one registered read port,
// a post-reset clear sweep and out-of-range read flagging.
module ram_sync_param #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic clk,
  input  logic rst,
  ram_sync_param_if.slave bus
);

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  // One extra bit so DEPTH itself is representable when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  out_q;
  logic              out_valid_q;
  logic              rd_err_q;
  logic              busy_q;

  logic              wr_ok_s;
  logic              rd_ok_s;
  logic              wr_hit_s;
  logic [WIDTH-1:0]  rd_data_s;

  // Address range checks and write-first read data selection.
  always_comb begin
    wr_ok_s   = bus.en && ({1'b0, bus.wr_addr} < DEPTH_W);
    rd_ok_s   = ({1'b0, bus.rd_addr} < DEPTH_W);
    wr_hit_s  = wr_ok_s && rd_ok_s && (bus.wr_addr == bus.rd_addr);
    rd_data_s = '0;
    if (wr_hit_s) begin
      rd_data_s = bus.in;
    end else if (rd_ok_s) begin
      rd_data_s = mem_q[bus.rd_addr];
    end else begin
      rd_data_s = '0;
    end
  end

  // Clear sweep FSM, storage array and registered read response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      clr_ptr_q   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      rd_err_q    <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        INIT: begin
          mem_q[clr_ptr_q] <= '0;
          out_valid_q      <= 1'b0;
          rd_err_q         <= 1'b0;
          if (clr_ptr_q == LAST_ADDR) begin
            state_q   <= READY;
            busy_q    <= 1'b0;
            clr_ptr_q <= '0;
          end else begin
            clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
          end
        end
        READY: begin
          if (wr_ok_s) begin
            mem_q[bus.wr_addr] <= bus.in;
          end
          if (bus.read) begin
            out_q       <= rd_data_s;
            out_valid_q <= 1'b1;
            rd_err_q    <= !rd_ok_s;
          end else begin
            out_valid_q <= 1'b0;
            rd_err_q    <= 1'b0;
          end
        end
        default: begin
          state_q     <= INIT;
          clr_ptr_q   <= '0;
          out_valid_q <= 1'b0;
          rd_err_q    <= 1'b0;
          busy_q      <= 1'b1;
        end
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.rd_err    = rd_err_q;
  assign bus.busy      = busy_q;

endmodule
